core_controller_axil_master: RTL and testbench
==============================================

// Module: core_controller_axil_master
// PURPOSE
//  AXI4-Lite master (initiator) that drives the core-controller register file from a simple command port.
//  Each accepted command becomes one AXI write (AW+W+B) or one AXI read (AR+R).
//  The result is returned on a response port. Processes one transaction at a time (no outstanding overlap).
//  Used by the host-side sequencer and by the test harness to write CRST/CEXEC/CMEM_ADDR and poll CSTAT.
// PARAMETERS
//  C_M_AXI_DATA_WIDTH  32    AXI data width; only 32 is supported
//  C_M_AXI_ADDR_WIDTH  16    AXI address width
//  TIMEOUT_CYCLES      1024  cycles a transaction may stay outstanding before abort (CORE_AXIL_TIMEOUT_EN only)
// PORTS
//  M_AXI_ACLK     in   1   single clock for all logic
//  M_AXI_ARST     in   1   synchronous reset, active-high
//  CMD_VALID      in   1   command request
//  CMD_READY      out  1   command accepted when CMD_VALID&&CMD_READY
//  CMD_WRITE      in   1   1=write, 0=read
//  CMD_ADDR       in   AW  byte address (low 2 bits ignored, driven as 0)
//  CMD_WDATA      in   DW  write data
//  RSP_VALID      out  1   response available
//  RSP_READY      in   1   response consumed when RSP_VALID&&RSP_READY
//  RSP_RDATA      out  DW  read data (0 for writes)
//  RSP_RESP       out  2   BRESP/RRESP as returned by the slave
//  RSP_TIMEOUT    out  1   transaction aborted by watchdog
//  M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB(4)/WVALID/WREADY, M_AXI_BRESP(2)/BVALID/BREADY,
//  M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP(2)/RVALID/RREADY   standard AXI4-Lite master signals
// BEHAVIOUR
//  Reset: state=IDLE; CMD_READY=0 during reset, 1 from first cycle after reset; all *VALID/*READY outputs=0;
//    RSP_VALID=0, RSP_RDATA=0, RSP_RESP=0, RSP_TIMEOUT=0. All outputs registered.
//  FSM: IDLE -> WR (write) or RD_A (read) -> WR_B / RD_D -> RSP -> IDLE.
//  IDLE: CMD_READY=1; on handshake, latch addr/data/dir. Next cycle AWVALID+WVALID (write) or ARVALID (read) =1.
//  WR: AW and W tracked independently (aw_done, w_done flags); each VALID drops the cycle after its own READY.
//    READY may precede, coincide with, or follow VALID. Leave WR when both done; WSTRB=4'hF always.
//  WR_B: BREADY=1; on BVALID capture BRESP, RSP_RDATA=0, go RSP.
//  RD_A: ARVALID held until ARREADY; RD_D: RREADY=1; on RVALID capture RDATA/RRESP, go RSP.
//  RSP: RSP_VALID=1 with stable payload until RSP_READY; then IDLE, CMD_READY=1 next cycle.
//  Latency with zero-wait slave: cmd accept at N -> VALIDs at N+1 -> resp at N+2 -> RSP_VALID at N+3.
//  CMD_READY=0 outside IDLE; back-to-back commands are separated by at least one IDLE cycle.
//  VALID never drops before handshake (except watchdog abort).
//  ADDR/DATA stable while VALID.
//  Reset mid-transaction: all VALID/READY deassert next cycle; the in-flight response is discarded; no RSP_VALID.
// CONFIGURATION
//  CORE_AXIL_TIMEOUT_EN defined: a counter runs in WR/WR_B/RD_A/RD_D and clears on each state entry.
//    At TIMEOUT_CYCLES all VALID/READY drop and the FSM goes to RSP with RSP_TIMEOUT=1, RSP_RESP=2'b10, RSP_RDATA=0.
//    Debug aid only: dropping VALID violates AXI, and the slave must be reset afterwards.
//  Not defined: no counter; RSP_TIMEOUT tied 0; a hung slave stalls the FSM indefinitely.
// STRUCTURE
//  Package core_axil_pkg: FSM state enum; RESP_OKAY/EXOKAY/SLVERR/DECERR codes.
//    Register offsets: CRST 16'h0000, CEXEC 16'h0004, CMEM_ADDR 16'h0008, CSTAT 16'h000C.
//  Sub-module core_axil_watchdog: loadable down-counter with expire pulse, instantiated only under CORE_AXIL_TIMEOUT_EN.
// TESTING
//  1 Write 0x0000_0001 to 16'h0000, zero-wait slave
//    -> AW/W valid at N+1; BRESP=OKAY; RSP_VALID at N+3; RSP_RESP=0.
//  2 AWREADY 3 cycles before WREADY (and the reverse)
//    -> each VALID drops right after its own handshake; exactly one B; one response.
//  3 Read 16'h000C, slave returns 0x0000_00A5 after 5 wait cycles
//    -> RSP_RDATA=0x0000_00A5, RSP_RESP=0.
//  4 Slave returns SLVERR on a read of 16'h0010 -> RSP_RESP=2'b10; RSP held stable with RSP_READY=0 for 4 cycles.
//  5 Assert M_AXI_ARST while AWVALID=1
//    -> all valids 0 next cycle; no RSP_VALID; a fresh command after reset completes normally.
//  6 CORE_AXIL_TIMEOUT_EN, TIMEOUT_CYCLES=16, BVALID never asserted
//    -> abort after 16 cycles in WR_B; RSP_TIMEOUT=1; RSP_RESP=2'b10.

Source files
------------

// File: rtl/core_axil_pkg.sv
// Shared types and constants for the core-controller AXI4-Lite master.
// The optional watchdog is enabled with the CORE_AXIL_TIMEOUT_EN macro.
package core_axil_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrB,
        StRdA,
        StRdD,
        StRsp
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [15:0] CRST      = 16'h0000;
    localparam logic [15:0] CEXEC     = 16'h0004;
    localparam logic [15:0] CMEM_ADDR = 16'h0008;
    localparam logic [15:0] CSTAT     = 16'h000C;

endpackage

// File: rtl/core_controller_axil_master_if.sv
// AXI4-Lite bus bundle between the core-controller master and its register-file slave.
interface core_controller_axil_master_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   M_AXI_AWADDR;
    logic                M_AXI_AWVALID;
    logic                M_AXI_AWREADY;
    logic [DATA_W-1:0]   M_AXI_WDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic                M_AXI_WVALID;
    logic                M_AXI_WREADY;
    logic [1:0]          M_AXI_BRESP;
    logic                M_AXI_BVALID;
    logic                M_AXI_BREADY;
    logic [ADDR_W-1:0]   M_AXI_ARADDR;
    logic                M_AXI_ARVALID;
    logic                M_AXI_ARREADY;
    logic [DATA_W-1:0]   M_AXI_RDATA;
    logic [1:0]          M_AXI_RRESP;
    logic                M_AXI_RVALID;
    logic                M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );

endinterface

// File: rtl/core_axil_watchdog.sv
// Loadable down-counter; expire_o pulses once Cycles cycles have elapsed since load_i.
// Only instantiated when CORE_AXIL_TIMEOUT_EN is defined.
module core_axil_watchdog #(
    parameter int unsigned Cycles = 1024  // must be >= 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (Cycles > 2) ? $clog2(Cycles) : 1;

    logic [CntW-1:0] cnt_q;

    // load_i marks the first cycle of a state, so the count covers the remaining Cycles-1
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CntW'(Cycles - 2);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/core_controller_axil_master.sv
// AXI4-Lite master: one command -> one AXI write or read -> one response, strictly serial.
// Define CORE_AXIL_TIMEOUT_EN to add a watchdog that aborts a hung transaction.
module core_controller_axil_master
    import core_axil_pkg::*;
#(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARST,
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic                          CMD_WRITE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] CMD_WDATA,
    output logic                          RSP_VALID,
    input  logic                          RSP_READY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] RSP_RDATA,
    output logic [1:0]                    RSP_RESP,
    output logic                          RSP_TIMEOUT,
    core_controller_axil_master_if.master m_axi
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

    state_e          state_q;
    logic            cmd_ready_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic            aw_done_q, w_done_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q, rsp_rdata_q;
    logic            rsp_valid_q, rsp_timeout_q;
    logic [1:0]      rsp_resp_q;
    logic            aw_hs, w_hs, wd_expire;

    assign aw_hs = awvalid_q && m_axi.M_AXI_AWREADY;
    assign w_hs  = wvalid_q && m_axi.M_AXI_WREADY;

`ifdef CORE_AXIL_TIMEOUT_EN
    state_e prev_state_q;
    logic   wd_busy;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARST) prev_state_q <= StIdle;
        else            prev_state_q <= state_q;
    end

    assign wd_busy = (state_q == StWr) || (state_q == StWrB) ||
                     (state_q == StRdA) || (state_q == StRdD);

    // Reload on every state change so each AXI phase gets its own budget
    core_axil_watchdog #(
        .Cycles (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (M_AXI_ACLK),
        .rst_i    (M_AXI_ARST),
        .load_i   (state_q != prev_state_q),
        .en_i     (wd_busy),
        .expire_o (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARST) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else if (wd_expire) begin
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_timeout_q <= 1'b1;
            state_q       <= StRsp;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (CMD_VALID && cmd_ready_q) begin
                        cmd_ready_q   <= 1'b0;
                        addr_q        <= {CMD_ADDR[AW-1:2], 2'b00};
                        wdata_q       <= CMD_WDATA;
                        rsp_timeout_q <= 1'b0;
                        if (CMD_WRITE) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWr;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRdA;
                        end
                    end
                end
                StWr: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_q || aw_hs;
                    w_done_q  <= w_done_q || w_hs;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= StWrB;
                    end
                end
                StWrB: begin
                    if (m_axi.M_AXI_BVALID) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= m_axi.M_AXI_BRESP;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRsp;
                    end
                end
                StRdA: begin
                    if (m_axi.M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdD;
                    end
                end
                StRdD: begin
                    if (m_axi.M_AXI_RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= m_axi.M_AXI_RDATA;
                        rsp_resp_q  <= m_axi.M_AXI_RRESP;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StRsp;
                    end
                end
                StRsp: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign CMD_READY           = cmd_ready_q;
    assign RSP_VALID           = rsp_valid_q;
    assign RSP_RDATA           = rsp_rdata_q;
    assign RSP_RESP            = rsp_resp_q;
    assign RSP_TIMEOUT         = rsp_timeout_q;
    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = '1;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = addr_q;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_core_controller_axil_master.sv
// Directed bench for core_controller_axil_master with a response scoreboard.
// Build with CORE_AXIL_TIMEOUT_EN defined to also exercise the watchdog abort.
module tb_core_controller_axil_master;
    import core_axil_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        timeout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CMD_VALID = 1'b0, CMD_WRITE = 1'b0, RSP_READY = 1'b0;
    logic [15:0] CMD_ADDR = '0;
    logic [31:0] CMD_WDATA = '0;
    logic        CMD_READY, RSP_VALID, RSP_TIMEOUT;
    logic [31:0] RSP_RDATA;
    logic [1:0]  RSP_RESP;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    core_controller_axil_master_if #(.ADDR_W(16), .DATA_W(32)) axi ();

    core_controller_axil_master #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (16),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .M_AXI_ACLK  (clk),
        .M_AXI_ARST  (rst),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_WRITE   (CMD_WRITE),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_WDATA   (CMD_WDATA),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_RDATA   (RSP_RDATA),
        .RSP_RESP    (RSP_RESP),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .m_axi       (axi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input int max_wait, input int hold);
        exp_t e;
        int   w = 0;
        while (RSP_VALID !== 1'b1 && w < max_wait) begin
            tick();
            w++;
        end
        chk("rsp_valid_arrives", RSP_VALID, 1);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL scoreboard_underflow observed=empty expected=entry");
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid_held", RSP_VALID, 1);
            chk("rsp_rdata", RSP_RDATA, e.rdata);
            chk("rsp_resp", RSP_RESP, e.resp);
            chk("rsp_timeout", RSP_TIMEOUT, e.timeout);
            chk("cmd_ready_busy", CMD_READY, 0);
            if (h < hold) tick();
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        chk("rsp_valid_drop", RSP_VALID, 0);
        chk("cmd_ready_back", CMD_READY, 1);
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d);
        chk("cmd_ready_idle", CMD_READY, 1);
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = a;
        CMD_WDATA = d;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input int aw_dly,
                             input int w_dly, input logic [1:0] bresp);
        int last = (aw_dly > w_dly) ? aw_dly : w_dly;
        sb.push_back('{rdata: 32'h0, resp: bresp, timeout: 1'b0});
        issue(1'b1, a, d);
        for (int c = 0; c <= last; c++) begin
            chk("awvalid", axi.M_AXI_AWVALID, c <= aw_dly);
            chk("wvalid", axi.M_AXI_WVALID, c <= w_dly);
            if (c == 0) begin
                chk("awaddr", axi.M_AXI_AWADDR, a & 16'hFFFC);
                chk("wdata", axi.M_AXI_WDATA, d);
                chk("wstrb", axi.M_AXI_WSTRB, 4'hF);
            end
            axi.M_AXI_AWREADY = (c == aw_dly);
            axi.M_AXI_WREADY  = (c == w_dly);
            tick();
        end
        axi.M_AXI_AWREADY = 1'b0;
        axi.M_AXI_WREADY  = 1'b0;
        chk("awvalid_done", axi.M_AXI_AWVALID, 0);
        chk("wvalid_done", axi.M_AXI_WVALID, 0);
        chk("bready", axi.M_AXI_BREADY, 1);
        axi.M_AXI_BVALID = 1'b1;
        axi.M_AXI_BRESP  = bresp;
        tick();
        axi.M_AXI_BVALID = 1'b0;
        axi.M_AXI_BRESP  = RESP_OKAY;
        chk("bready_single", axi.M_AXI_BREADY, 0);
        wait_rsp(0, 0);
    endtask

    task automatic axi_read(input logic [15:0] a, input logic [31:0] rd, input int ar_dly,
                            input int r_dly, input logic [1:0] rresp, input int hold);
        sb.push_back('{rdata: rd, resp: rresp, timeout: 1'b0});
        issue(1'b0, a, 32'hDEAD_BEEF);
        for (int c = 0; c <= ar_dly; c++) begin
            chk("arvalid", axi.M_AXI_ARVALID, 1);
            chk("araddr", axi.M_AXI_ARADDR, a & 16'hFFFC);
            axi.M_AXI_ARREADY = (c == ar_dly);
            tick();
        end
        axi.M_AXI_ARREADY = 1'b0;
        chk("arvalid_done", axi.M_AXI_ARVALID, 0);
        for (int c = 0; c < r_dly; c++) begin
            chk("rready_wait", axi.M_AXI_RREADY, 1);
            tick();
        end
        axi.M_AXI_RVALID = 1'b1;
        axi.M_AXI_RDATA  = rd;
        axi.M_AXI_RRESP  = rresp;
        tick();
        axi.M_AXI_RVALID = 1'b0;
        axi.M_AXI_RDATA  = '0;
        axi.M_AXI_RRESP  = RESP_OKAY;
        chk("rready_done", axi.M_AXI_RREADY, 0);
        wait_rsp(0, hold);
    endtask

    initial begin
        axi.M_AXI_AWREADY = 1'b0;
        axi.M_AXI_WREADY  = 1'b0;
        axi.M_AXI_BVALID  = 1'b0;
        axi.M_AXI_BRESP   = RESP_OKAY;
        axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_RVALID  = 1'b0;
        axi.M_AXI_RDATA   = '0;
        axi.M_AXI_RRESP   = RESP_OKAY;

        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready", CMD_READY, 0);
        chk("rst_awvalid", axi.M_AXI_AWVALID, 0);
        chk("rst_wvalid", axi.M_AXI_WVALID, 0);
        chk("rst_arvalid", axi.M_AXI_ARVALID, 0);
        chk("rst_bready", axi.M_AXI_BREADY, 0);
        chk("rst_rready", axi.M_AXI_RREADY, 0);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_rsp_rdata", RSP_RDATA, 0);
        chk("rst_rsp_resp", RSP_RESP, 0);
        chk("rst_rsp_timeout", RSP_TIMEOUT, 0);
        rst = 1'b0;
        tick();
        tick();

        // Zero-wait write: VALIDs at N+1, response at N+3
        axi_write(CRST, 32'h0000_0001, 0, 0, RESP_OKAY);

        // Read with 5 wait cycles, unaligned address
        axi_read(CSTAT | 16'h0003, 32'h0000_00A5, 0, 5, RESP_OKAY, 0);

        // Skewed AW/W handshakes in both orders; write returns zero rdata after a read
        axi_write(CEXEC, 32'hCAFE_0004, 0, 3, RESP_OKAY);
        axi_write(CMEM_ADDR, 32'h1234_5678, 3, 0, RESP_DECERR);
        axi_write(CEXEC, 32'h0000_00FF, 2, 2, RESP_EXOKAY);

        // SLVERR read held with RSP_READY low for 4 cycles
        axi_read(16'h0010, 32'h0BAD_0BAD, 2, 0, RESP_SLVERR, 4);

        // Reset while AWVALID is high: everything drops, no response
        issue(1'b1, CMEM_ADDR, 32'hAAAA_5555);
        chk("pre_rst_awvalid", axi.M_AXI_AWVALID, 1);
        rst = 1'b1;
        tick();
        chk("midrst_awvalid", axi.M_AXI_AWVALID, 0);
        chk("midrst_wvalid", axi.M_AXI_WVALID, 0);
        chk("midrst_bready", axi.M_AXI_BREADY, 0);
        chk("midrst_cmd_ready", CMD_READY, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_rsp", RSP_VALID, 0);
            tick();
        end
        axi_write(CMEM_ADDR, 32'h0000_0055, 0, 0, RESP_OKAY);
        axi_read(CRST, 32'h0000_0001, 1, 1, RESP_OKAY, 0);

`ifdef CORE_AXIL_TIMEOUT_EN
        // Hung B channel: abort after 16 cycles in WR_B
        sb.push_back('{rdata: 32'h0, resp: RESP_SLVERR, timeout: 1'b1});
        issue(1'b1, CEXEC, 32'h0000_0007);
        axi.M_AXI_AWREADY = 1'b1;
        axi.M_AXI_WREADY  = 1'b1;
        tick();
        axi.M_AXI_AWREADY = 1'b0;
        axi.M_AXI_WREADY  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("wd_bready_hold", axi.M_AXI_BREADY, 1);
            chk("wd_no_rsp_yet", RSP_VALID, 0);
            tick();
        end
        chk("wd_bready_drop", axi.M_AXI_BREADY, 0);
        wait_rsp(0, 0);
        axi_write(CRST, 32'h0000_0000, 0, 0, RESP_OKAY);
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
